// File: rtl/trx_pkg.sv
// Shared mode encodings and FSM state type for the TX/RX shift-register sequencer.
package trx_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [1:0] shift_mode(input bit dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/trx_sequencer_if.sv
// Handshake and shift-register control bundle between the sequencer and its surroundings.
interface trx_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [1:0]       tx_sel;
  logic [WIDTH-1:0] tx_load_data;
  logic [1:0]       rx_sel;
  logic [WIDTH-1:0] rx_par;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             busy;

  modport slave (
    input  tx_data, tx_valid, rx_par, rx_ready,
    output tx_ready, tx_sel, tx_load_data, rx_sel, rx_data, rx_valid, busy
  );

  modport master (
    output tx_data, tx_valid, rx_par, rx_ready,
    input  tx_ready, tx_sel, tx_load_data, rx_sel, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/trx_sequencer_bit_counter.sv
// Bit counter for the SHIFT phase: counts 0..WIDTH-1 and saturates at terminal count.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = (count_q == LAST);

  // Holding at LAST keeps the counter from wrapping if enable lingers.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && !tc_o)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/trx_sequencer.sv
// Moore FSM that sequences a TX/RX universal shift-register pair through load, shift,
// capture and a valid/ready hand-off of the received word.
module trx_sequencer
  import trx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit DIR   = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  trx_sequencer_if.slave  bus
);
  state_e           state_q, state_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] tx_load_data_q, tx_load_data_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [1:0]       tx_mode, rx_mode;
  logic             cnt_tc;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == ST_LOAD),
    .enable_i (state_q == ST_SHIFT),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    tx_load_data_d = tx_load_data_q;
    rx_data_d      = rx_data_q;
    tx_mode        = MODE_HOLD;
    rx_mode        = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_load_data_d = bus.tx_data;
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_mode = MODE_LOAD;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        tx_mode = shift_mode(DIR);
        rx_mode = shift_mode(DIR);
        if (cnt_tc)
          state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rx_data_d = bus.rx_par;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rx_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready stays low for the first cycle out of reset.
    tx_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      tx_ready_q     <= 1'b0;
      tx_load_data_q <= '0;
      rx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      tx_ready_q     <= tx_ready_d;
      tx_load_data_q <= tx_load_data_d;
      rx_data_q      <= rx_data_d;
    end
  end

  assign bus.tx_ready     = tx_ready_q;
  assign bus.tx_sel       = tx_mode;
  assign bus.rx_sel       = rx_mode;
  assign bus.tx_load_data = tx_load_data_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = (state_q == ST_DONE);
  assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: doc/trx_sequencer.md
TRX_SEQUENCER -- requirements
Module: trx_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: word width of the TX and RX shift registers being sequenced.
REQ-002 Parameter DIR, default 0: 0 = shift right (mode 01, LSB first); 1 = shift left (mode 10, MSB first).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 tx_data  in  WIDTH  word to transmit.
REQ-006 tx_valid  in  1  tx_data is valid.
REQ-007 tx_ready  out  1  sequencer accepts a word; transfer occurs when tx_valid && tx_ready are high at a rising edge.
REQ-008 tx_sel  out  2  mode select to TX universal shift register: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-009 tx_load_data  out  WIDTH  parallel-load value for the TX register.
REQ-010 rx_sel  out  2  mode select to RX universal shift register, same encoding.
REQ-011 rx_par  in  WIDTH  parallel contents of the RX register.
REQ-012 rx_data  out  WIDTH  captured received word.
REQ-013 rx_valid  out  1  rx_data is valid.
REQ-014 rx_ready  in  1  consumer accepts rx_data.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPTURE and DONE; all outputs are registered or decoded from state only (Moore).
REQ-017 IDLE: tx_ready=1, tx_sel=rx_sel=00; on tx_valid, latch tx_data into tx_load_data and go to LOAD.
REQ-018 LOAD (1 cycle): tx_sel=11, rx_sel=00; clear bit counter; go to SHIFT.
REQ-019 SHIFT: tx_sel=rx_sel=shift mode selected by DIR, for exactly WIDTH cycles; the counter runs 0..WIDTH-1 and the FSM goes to CAPTURE when the counter reaches WIDTH-1.
REQ-020 Counter width SHALL be $clog2(WIDTH); the counter SHALL never wrap inside SHIFT.
REQ-021 CAPTURE (1 cycle): tx_sel=rx_sel=00; rx_data<=rx_par at the end of the cycle; go to DONE.
REQ-022 DONE: rx_valid=1 and rx_data held stable until rx_ready=1 at a rising edge, then go to IDLE and drop rx_valid.
REQ-023 Latency: with acceptance at edge 0, rx_valid SHALL be first high in cycle WIDTH+3 (11 cycles for WIDTH=8).
REQ-024 tx_ready SHALL be 0 outside IDLE; tx_valid and tx_data changes while busy are ignored.
REQ-025 With rx_ready held high, DONE SHALL last 1 cycle, and tx_ready returns 1 on the following cycle (no same-cycle re-accept).
REQ-026 tx_load_data SHALL remain stable from LOAD through DONE.

Reset
REQ-027 While RST_N=0: state=IDLE, counter=0, tx_sel=rx_sel=00, tx_load_data=0, rx_data=0, rx_valid=0, busy=0, tx_ready=0.
REQ-028 On reset deassertion, tx_ready SHALL be 1 from the first rising edge onward; a transfer aborted by reset SHALL NOT produce rx_valid.

Structure
REQ-029 Shared package trx_pkg SHALL hold the mode constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the state encoding.
REQ-030 The bit counter SHALL be a sub-module bit_counter (clear, enable, terminal-count output), parameterised by WIDTH.

Verification
REQ-031 Loopback bench: the TX register serial output feeds the RX register serial input; DIR=0, send 8'hAA with rx_ready=1 -> rx_data=8'hAA, rx_valid high for 1 cycle, 11 cycles after acceptance.
REQ-032 DIR=1, send 8'h81 -> rx_sel and tx_sel = 10 for exactly 8 cycles; rx_data=8'h81.
REQ-033 Hold rx_ready=0 for 5 cycles in DONE -> rx_valid stays 1, rx_data is stable, tx_ready stays 0, and the FSM goes to IDLE after rx_ready rises.
REQ-034 Toggle tx_valid and tx_data (8'h55) during SHIFT -> no effect; the first word is received intact.
REQ-035 Assert RST_N=0 at SHIFT count 4 -> all outputs go to reset values immediately, and no rx_valid pulse follows.
REQ-036 Back-to-back words 8'h01 and 8'hFE with tx_valid held high -> both are received in order, with one IDLE cycle between them.
